// File: rtl/serial_logic_unit_if.sv
// Handshake/operand bundle for serial_logic_unit.
//   start  : request, sampled only while the unit is idle
//   funct  : MIPS R-type funct code (AND/OR/XOR/NOR)
//   a, b   : WIDTH-bit operands, captured with start
//   busy   : high while slices are being evaluated
//   done   : one-cycle completion pulse
//   err    : unsupported funct flag, held until the next accepted start
//   result : result register
// master drives the request side; slave is the execution unit.
interface serial_logic_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [5:0]       funct;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] result;

   modport master (output start, funct, a, b,
                   input  busy, done, err, result);
   modport slave  (input  start, funct, a, b,
                   output busy, done, err, result);
endinterface

// File: rtl/serial_logic_unit.sv
// Bit-serial logic unit: evaluates AND/OR/XOR/NOR on two WIDTH-bit operands,
// STEP bits per clock, LSB slice first.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : serial_logic_unit_if.slave (start/funct/a/b in, busy/done/err/result out)
// STEP must divide WIDTH; one operation takes N = WIDTH/STEP RUN cycles plus
// one DONE cycle.
module serial_logic_unit #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_logic_unit_if.slave   bus
);

   localparam int N  = WIDTH / STEP;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [1:0]       op_sel;
   logic [WIDTH-1:0] result_q;
   logic             err_q;

   logic             supported;
   logic [STEP-1:0]  slice;
   logic [WIDTH-1:0] slice_ext;
   logic [31:0]      shamt;

   // 6'h24..6'h27 share the upper four bits; the low two select the op.
   assign supported = (bus.funct[5:2] == 4'b1001);

   // Operands are shifted right each RUN cycle, so the current slice always
   // sits at the bottom; only the result needs positional placement.
   always_comb begin
      slice = '0;
      case (op_sel)
         2'b00: slice = a_sh[STEP-1:0] & b_sh[STEP-1:0];
         2'b01: slice = a_sh[STEP-1:0] | b_sh[STEP-1:0];
         2'b10: slice = a_sh[STEP-1:0] ^ b_sh[STEP-1:0];
         2'b11: slice = ~(a_sh[STEP-1:0] | b_sh[STEP-1:0]);
         default: slice = '0;
      endcase
      slice_ext            = '0;
      slice_ext[STEP-1:0]  = slice;
      shamt                = 32'(cnt) * STEP;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.start) state_nxt = supported ? RUN : DONE;
         RUN:  if (cnt == LAST) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         a_sh     <= '0;
         b_sh     <= '0;
         op_sel   <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  result_q <= '0;
                  cnt      <= '0;
                  if (supported) begin
                     a_sh   <= bus.a;
                     b_sh   <= bus.b;
                     op_sel <= bus.funct[1:0];
                     err_q  <= 1'b0;
                  end else begin
                     err_q  <= 1'b1;
                  end
               end
            end
            RUN: begin
               // Unwritten slices are still zero, so OR-ing places the slice.
               result_q <= result_q | (slice_ext << shamt);
               a_sh     <= a_sh >> STEP;
               b_sh     <= b_sh >> STEP;
               if (cnt != LAST) cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = (state == RUN);
   assign bus.done   = (state == DONE);
   assign bus.err    = err_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Self-checking bench for serial_logic_unit: one instance with STEP=1 and one
// with STEP=8, table vectors, hand-written multi-cycle sequences and
// randomized operations against a word-level reference model.
module tb_serial_logic_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   serial_logic_unit_if #(.WIDTH(32)) bus1 ();
   serial_logic_unit_if #(.WIDTH(32)) bus8 ();

   serial_logic_unit #(.WIDTH(32), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   serial_logic_unit #(.WIDTH(32), .STEP(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int          d;       // 0: STEP=1 instance, 1: STEP=8 instance
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  f;
      logic [31:0] exp_res;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Word-level reference: the serial unit must end up with the plain bitwise result.
   function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                           input logic [5:0] f);
      case (f)
         6'h24: return a & b;
         6'h25: return a | b;
         6'h26: return a ^ b;
         6'h27: return ~(a | b);
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit ref_ok(input logic [5:0] f);
      return (f >= 6'h24) && (f <= 6'h27);
   endfunction

   function automatic logic o_busy(input int d);   return d ? bus8.busy   : bus1.busy;   endfunction
   function automatic logic o_done(input int d);   return d ? bus8.done   : bus1.done;   endfunction
   function automatic logic o_err(input int d);    return d ? bus8.err    : bus1.err;    endfunction
   function automatic logic [31:0] o_res(input int d); return d ? bus8.result : bus1.result; endfunction

   task automatic set_in(input int d, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] f);
      if (d == 0) begin
         bus1.start = s; bus1.a = a; bus1.b = b; bus1.funct = f;
      end else begin
         bus8.start = s; bus8.a = a; bus8.b = b; bus8.funct = f;
      end
   endtask

   // Issue one operation; optionally pulse a second start at sample index inj.
   // lat = number of edges after the start edge until done is seen.
   task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] f, input int inj,
                         output logic [31:0] res, output logic e,
                         output int lat, output int bcnt);
      res = 32'h0; e = 1'b0; lat = -1; bcnt = 0;
      @(negedge clk);
      set_in(d, 1'b1, a, b, f);
      @(posedge clk); #1;
      set_in(d, 1'b0, a, b, f);
      for (int j = 0; j < 100; j++) begin
         if (j == inj) set_in(d, 1'b1, ~a, b ^ 32'h5A5A_A5A5, 6'h26);
         else          set_in(d, 1'b0, ~a, b ^ 32'h5A5A_A5A5, 6'h26);
         if (o_busy(d)) bcnt++;
         if (o_done(d)) begin
            lat = j; res = o_res(d); e = o_err(d);
            break;
         end
         @(posedge clk); #1;
      end
      set_in(d, 1'b0, a, b, f);
      @(posedge clk); #1;
      chk("done_one_cycle", {31'b0, o_done(d)}, 32'h0);
      chk("idle_after_done", {31'b0, o_busy(d)}, 32'h0);
   endtask

   task automatic check_vec(input string tag, input vec_t v, input int inj);
      logic [31:0] res; logic e; int lat; int bcnt;
      run_op(v.d, v.a, v.b, v.f, inj, res, e, lat, bcnt);
      chk({tag, "_result"}, res, v.exp_res);
      chk({tag, "_err"}, {31'b0, e}, {31'b0, v.exp_err});
      chk({tag, "_latency"}, lat, v.exp_lat);
      chk({tag, "_busy_cycles"}, bcnt, v.exp_lat);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r; logic e; int lat; int bc;
      vec_t v;

      tbl[0] = '{0, 32'hF0F0_0000, 32'h0000_0F0F, 6'h25, 32'hF0F0_0F0F, 1'b0, 32};
      tbl[1] = '{0, 32'h0000_FFFF, 32'h00FF_0000, 6'h27, 32'hFF00_0000, 1'b0, 32};
      tbl[2] = '{1, 32'h1234_5678, 32'h0F0F_FFFF, 6'h24, 32'h0204_5678, 1'b0, 4};
      tbl[3] = '{1, 32'h1234_5678, 32'h0F0F_FFFF, 6'h26, 32'h1D3B_A987, 1'b0, 4};
      tbl[4] = '{0, 32'hDEAD_BEEF, 32'h1234_5678, 6'h20, 32'h0000_0000, 1'b1, 0};
      tbl[5] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h2A, 32'h0000_0000, 1'b1, 0};

      set_in(0, 1'b0, '0, '0, '0);
      set_in(1, 1'b0, '0, '0, '0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("reset_busy",   {31'b0, o_busy(d)}, 32'h0);
         chk("reset_done",   {31'b0, o_done(d)}, 32'h0);
         chk("reset_err",    {31'b0, o_err(d)},  32'h0);
         chk("reset_result", o_res(d),           32'h0);
      end
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) check_vec($sformatf("tbl%0d", i), tbl[i], -1);

      // err and zero result persist after an unsupported request.
      repeat (3) @(posedge clk);
      #1;
      chk("err_held",    {31'b0, o_err(1)}, 32'h1);
      chk("err_held_res", o_res(1),         32'h0);

      // Mid-run probe, STEP=8 AND: two slices written after the 2nd RUN edge.
      @(negedge clk);
      set_in(1, 1'b1, 32'h1234_5678, 32'h0F0F_FFFF, 6'h24);
      @(posedge clk); #1;
      set_in(1, 1'b0, 32'h0, 32'h0, 6'h0);
      chk("probe_err_cleared", {31'b0, o_err(1)}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("probe_partial", o_res(1), 32'h0000_5678);
      chk("probe_busy", {31'b0, o_busy(1)}, 32'h1);
      repeat (2) @(posedge clk);
      #1;
      chk("probe_done", {31'b0, o_done(1)}, 32'h1);
      chk("probe_final", o_res(1), 32'h0204_5678);

      // Reset mid-RUN, STEP=1 OR: rst at edge t+10, new start at t+12.
      @(negedge clk);
      set_in(0, 1'b1, 32'hF0F0_0000, 32'h0000_0F0F, 6'h25);
      @(posedge clk); #1;
      set_in(0, 1'b0, 32'h0, 32'h0, 6'h0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rstrun_busy",   {31'b0, o_busy(0)}, 32'h0);
      chk("rstrun_done",   {31'b0, o_done(0)}, 32'h0);
      chk("rstrun_result", o_res(0),           32'h0);
      @(negedge clk);
      rst = 1'b0;
      v = '{0, 32'h0F0F_0F0F, 32'h0000_FFFF, 6'h25, 32'h0F0F_FFFF, 1'b0, 32};
      check_vec("rstrun_restart", v, -1);

      // start together with rst: reset wins, request dropped.
      @(negedge clk);
      rst = 1'b1;
      set_in(0, 1'b1, 32'hFFFF_FFFF, 32'h0, 6'h25);
      @(posedge clk); #1;
      set_in(0, 1'b0, 32'h0, 32'h0, 6'h0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_start_busy", {31'b0, o_busy(0)}, 32'h0);
      chk("rst_start_res",  o_res(0),           32'h0);

      // Second start during RUN is ignored (both widths).
      v = '{0, 32'hA5A5_1234, 32'h0F0F_00FF, 6'h24, 32'hA5A5_1234 & 32'h0F0F_00FF, 1'b0, 32};
      check_vec("ignored_start1", v, 5);
      v = '{1, 32'hA5A5_1234, 32'h0F0F_00FF, 6'h25, 32'hA5A5_1234 | 32'h0F0F_00FF, 1'b0, 4};
      check_vec("ignored_start8", v, 1);

      // Randomized operations against the word-level model.
      for (int i = 0; i < 24; i++) begin
         int sel;
         v.d = int'($urandom_range(0, 1));
         v.a = $urandom;
         v.b = $urandom;
         sel = int'($urandom_range(0, 4));
         if (sel < 4) v.f = 6'h24 + 6'(sel);
         else begin
            v.f = 6'($urandom_range(0, 63));
            if (ref_ok(v.f)) v.f = v.f ^ 6'h10;
         end
         v.exp_res = ref_res(v.a, v.b, v.f);
         v.exp_err = !ref_ok(v.f);
         v.exp_lat = ref_ok(v.f) ? (v.d ? 4 : 32) : 0;
         check_vec($sformatf("rnd%0d", i), v, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
